// File: rtl/imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_ctrl
// Description : RV32I immediate/rd decoder feeding a 2-entry in-order buffer
//               with valid/ready handshakes, flush and illegal-opcode counting.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_ctrl #(
    parameter int DROP_ILLEGAL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_imm_sel,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    localparam logic [2:0] c_sel_i   = 3'd0;
    localparam logic [2:0] c_sel_s   = 3'd1;
    localparam logic [2:0] c_sel_b   = 3'd2;
    localparam logic [2:0] c_sel_u   = 3'd3;
    localparam logic [2:0] c_sel_j   = 3'd4;
    localparam logic [2:0] c_sel_r   = 3'd5;
    localparam logic [2:0] c_sel_ill = 3'd7;
    localparam logic [7:0] c_cnt_max = 8'hFF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    state_t      r_state;
    entry_t      r_head;
    entry_t      r_tail;
    logic [7:0]  r_cnt;

    entry_t      w_new;
    logic [6:0]  w_opcode;
    logic        w_push;
    logic        w_pop;
    logic        w_store;

    assign w_opcode = instruction[6:0];

    always_comb begin
        w_new     = '0;
        w_new.pc  = pc;
        w_new.sel = c_sel_ill;
        w_new.ill = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w_new.sel = c_sel_i;
                w_new.imm = {{20{instruction[31]}}, instruction[31:20]};
                w_new.rd  = instruction[11:7];
            end
            7'b0100011: begin
                w_new.sel = c_sel_s;
                w_new.imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                w_new.sel = c_sel_b;
                w_new.imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_new.sel = c_sel_u;
                w_new.imm = {instruction[31:12], 12'b0};
                w_new.rd  = instruction[11:7];
            end
            7'b1101111: begin
                w_new.sel = c_sel_j;
                w_new.imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
                w_new.rd  = instruction[11:7];
            end
            7'b0110011: begin
                w_new.sel = c_sel_r;
                w_new.rd  = instruction[11:7];
            end
            default: begin
                w_new.sel = c_sel_ill;
                w_new.ill = 1'b1;
            end
        endcase
    end

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // Dropped illegal instructions complete the handshake but never occupy a slot.
    assign w_store   = w_push && !((DROP_ILLEGAL != 0) && w_new.ill);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= 8'd0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push && w_new.ill && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_store) begin
                        r_head  <= w_new;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_store && w_pop) begin
                        r_head <= w_new;
                    end else if (w_store) begin
                        r_tail  <= w_new;
                        r_state <= ST_FULL;
                    end else if (w_pop) begin
                        // Head is cleared so data outputs read zero while empty.
                        r_head  <= '0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_tail  <= '0;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_head  <= '0;
                    r_tail  <= '0;
                end
            endcase
        end
    end

    assign out_imm     = r_head.imm;
    assign out_imm_sel = r_head.sel;
    assign out_pc      = r_head.pc;
    assign out_rd      = r_head.rd;
    assign illegal     = r_head.ill;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_ctrl
// Description : Directed self-checking bench for imm_decode_ctrl (both
//               DROP_ILLEGAL settings instantiated side by side).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready0, out_valid0, illegal0;
    logic [31:0] out_imm0, out_pc0;
    logic [2:0]  out_imm_sel0;
    logic [4:0]  out_rd0;
    logic [7:0]  illegal_cnt0;

    logic        in_ready1, out_valid1, illegal1;
    logic [31:0] out_imm1, out_pc1;
    logic [2:0]  out_imm_sel1;
    logic [4:0]  out_rd1;
    logic [7:0]  illegal_cnt1;

    int checks = 0;
    int errors = 0;

    imm_decode_ctrl #(.DROP_ILLEGAL(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_imm(out_imm0),
        .out_imm_sel(out_imm_sel0), .out_pc(out_pc0), .out_rd(out_rd0),
        .illegal(illegal0), .illegal_cnt(illegal_cnt0)
    );

    imm_decode_ctrl #(.DROP_ILLEGAL(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_imm(out_imm1),
        .out_imm_sel(out_imm_sel1), .out_pc(out_pc1), .out_rd(out_rd1),
        .illegal(illegal1), .illegal_cnt(illegal_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [31:0] exp_pc);
        chk({name, " out_valid"}, {31'd0, out_valid0}, 32'd1);
        chk({name, " out_pc"}, out_pc0, exp_pc);
    endtask

    initial begin
        bit drop_ok;

        vecs[0]  = '{32'hFFF00093, 32'h00000100, 32'hFFFFFFFF, 3'd0, 5'd1};
        vecs[1]  = '{32'hFE000EE3, 32'h00000104, 32'hFFFFFFFC, 3'd2, 5'd0};
        vecs[2]  = '{32'h001000EF, 32'h00000108, 32'h00000800, 3'd4, 5'd1};
        vecs[3]  = '{32'hFE20AC23, 32'h0000010C, 32'hFFFFFFF8, 3'd1, 5'd0};
        vecs[4]  = '{32'h123452B7, 32'h00000110, 32'h12345000, 3'd3, 5'd5};
        vecs[5]  = '{32'hFFFFF197, 32'h00000114, 32'hFFFFF000, 3'd3, 5'd3};
        vecs[6]  = '{32'h002083B3, 32'h00000118, 32'h00000000, 3'd5, 5'd7};
        vecs[7]  = '{32'h7FF02203, 32'h0000011C, 32'h000007FF, 3'd0, 5'd4};
        vecs[8]  = '{32'h00008067, 32'h00000120, 32'h00000000, 3'd0, 5'd0};
        vecs[9]  = '{32'h00000863, 32'h00000124, 32'h00000010, 3'd2, 5'd0};
        vecs[10] = '{32'h00000073, 32'h00000128, 32'h00000000, 3'd0, 5'd0};
        vecs[11] = '{32'h80000037, 32'h0000012C, 32'h80000000, 3'd3, 5'd0};

        reset = 1'b1; in_valid = 1'b0; instruction = '0; pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst cnt", {24'd0, illegal_cnt0}, 32'd0);
        chk("rst out_imm", out_imm0, 32'd0);
        chk("rst out_pc", out_pc0, 32'd0);

        // Illegal forwarded (DROP=0) versus discarded (DROP=1)
        in_valid = 1'b1; instruction = 32'hFFFFFFFF; pc = 32'h200;
        step();
        in_valid = 1'b0;
        chk("ill out_valid", {31'd0, out_valid0}, 32'd1);
        chk("ill flag", {31'd0, illegal0}, 32'd1);
        chk("ill sel", {29'd0, out_imm_sel0}, 32'd7);
        chk("ill imm", out_imm0, 32'd0);
        chk("ill rd", {27'd0, out_rd0}, 32'd0);
        chk("ill cnt", {24'd0, illegal_cnt0}, 32'd1);
        chk("drop out_valid", {31'd0, out_valid1}, 32'd0);
        chk("drop cnt", {24'd0, illegal_cnt1}, 32'd1);
        step();
        chk("ill popped", {31'd0, out_valid0}, 32'd0);

        // Decode table: one push into EMPTY, check after one edge, then pop
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; instruction = vecs[i].inst; pc = vecs[i].pc;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid0}, 32'd1);
            chk($sformatf("vec%0d imm", i), out_imm0, vecs[i].imm);
            chk($sformatf("vec%0d sel", i), {29'd0, out_imm_sel0}, {29'd0, vecs[i].sel});
            chk($sformatf("vec%0d rd", i), {27'd0, out_rd0}, {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d pc", i), out_pc0, vecs[i].pc);
            chk($sformatf("vec%0d illegal", i), {31'd0, illegal0}, 32'd0);
            step();
            chk($sformatf("vec%0d drained", i), {31'd0, out_valid0}, 32'd0);
            chk($sformatf("vec%0d zero imm", i), out_imm0, 32'd0);
        end
        chk("cnt after legal", {24'd0, illegal_cnt0}, 32'd1);

        // Backpressure: three pushes with OUT_READY=0
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = vecs[0].inst; pc = 32'hA00;
        step();
        chk_head("bp A", 32'hA00);
        chk("bp ready after 1", {31'd0, in_ready0}, 32'd1);
        instruction = vecs[2].inst; pc = 32'hB00;
        step();
        chk("bp ready after 2", {31'd0, in_ready0}, 32'd0);
        chk_head("bp A hold", 32'hA00);
        instruction = vecs[4].inst; pc = 32'hC00;
        step();
        chk_head("bp A stable1", 32'hA00);
        chk("bp imm stable", out_imm0, 32'hFFFFFFFF);
        step();
        chk_head("bp A stable2", 32'hA00);
        chk("bp ready held", {31'd0, in_ready0}, 32'd0);
        out_ready = 1'b1;
        step();
        chk_head("bp B", 32'hB00);
        chk("bp B imm", out_imm0, 32'h00000800);
        step();
        in_valid = 1'b0;
        chk_head("bp C", 32'hC00);
        chk("bp C imm", out_imm0, 32'h12345000);
        step();
        chk("bp drained", {31'd0, out_valid0}, 32'd0);

        // Flush while FULL with an incoming push
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = vecs[0].inst; pc = 32'hD00;
        step();
        pc = 32'hD04;
        step();
        chk("fl full", {31'd0, in_ready0}, 32'd0);
        flush = 1'b1; pc = 32'hD08;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl out_valid", {31'd0, out_valid0}, 32'd0);
        chk("fl in_ready", {31'd0, in_ready0}, 32'd1);
        chk("fl out_pc", out_pc0, 32'd0);
        drop_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid0 !== 1'b0) drop_ok = 1'b0;
        end
        chk("fl no later output", {31'd0, drop_ok}, 32'd1);

        // Flush from ONE with same-cycle illegal push: not counted
        in_valid = 1'b1; out_ready = 1'b0; instruction = vecs[1].inst; pc = 32'hE00;
        step();
        flush = 1'b1; instruction = 32'hFFFFFFFF; pc = 32'hE04;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl1 out_valid", {31'd0, out_valid0}, 32'd0);
        chk("fl1 cnt", {24'd0, illegal_cnt0}, 32'd1);

        // 300 illegal pushes: DROP=1 never shows output, both counters saturate
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b1; instruction = 32'hFFFFFFFF; pc = 32'hF00;
        drop_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) drop_ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("drop300 no output", {31'd0, drop_ok}, 32'd1);
        chk("drop300 cnt1", {24'd0, illegal_cnt1}, 32'd255);
        chk("drop300 cnt0", {24'd0, illegal_cnt0}, 32'd255);
        step(); step();

        // Reset with flush while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = vecs[0].inst; pc = 32'h300;
        step(); step();
        chk("rf full", {31'd0, in_ready0}, 32'd0);
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rf out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rf in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rf cnt0", {24'd0, illegal_cnt0}, 32'd0);
        chk("rf cnt1", {24'd0, illegal_cnt1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
